pipe_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Arbitrates stall requests from IF/ID/EX/MEM into the
//  6-bit stall vector (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB) consumed by every stage register.

---
 rtl/pipe_ctrl_if.sv | 34 +++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the pipeline sequencer.
// master = stage side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic        stallreq_if_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic [31:0] except_type_i;
  logic [31:0] cp0_epc_i;
  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        stall_timeout_o;
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_count_o;

  modport master (
    output stallreq_if_i, stallreq_id_i,
    output stallreq_ex_i, stallreq_mem_i,
    output except_type_i, cp0_epc_i,
    input  stall_o, flush_o, new_pc_o,
    input  stall_timeout_o,
    input  stall_cycles_o, flush_count_o
  );

  modport slave (
    input  stallreq_if_i, stallreq_id_i,
    input  stallreq_ex_i, stallreq_mem_i,
    input  except_type_i, cp0_epc_i,
    output stall_o, flush_o, new_pc_o,
    output stall_timeout_o,
    output stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall arbitration, exception flush, stall watchdog.
// Optional perf counters built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
  parameter logic [15:0] STALL_TIMEOUT = 16'd1024,
  parameter int unsigned CNT_W         = 16
) (
  input logic     clk,
  input logic     Rst_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [31:0] ERET = 32'h0000_000e;
  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'(STALL_TIMEOUT - 16'd1);

  typedef enum logic {RUN, HOLD} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wd_q, wd_d;
  logic             to_q, to_d;
  logic [5:0]       arb;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;

  // Deepest requester wins.
  always_comb begin
    arb = 6'b000000;
    priority case (1'b1)
      bus.stallreq_mem_i: arb = 6'b011111;
      bus.stallreq_ex_i:  arb = 6'b001111;
      bus.stallreq_id_i:  arb = 6'b000111;
      bus.stallreq_if_i:  arb = 6'b000011;
      default:            arb = 6'b000000;
    endcase
  end

  always_comb begin
    state_d = state_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = 32'h0;
    if (Rst_n) begin
      stall = arb;
      unique case (state_q)
        RUN: begin
          if (bus.except_type_i != 32'h0) begin
            stall   = 6'b000000;
            flush   = 1'b1;
            new_pc  = (bus.except_type_i == ERET)
                    ? bus.cp0_epc_i : EXC_VECTOR;
            state_d = HOLD;
          end
        end
        HOLD: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    wd_d = wd_q;
    to_d = to_q;
    if (stall == 6'b0 || flush) begin
      wd_d = '0;
    end else begin
      if (wd_q != '1) wd_d = wd_q + 1'b1;
      if (wd_q >= WD_LAST) to_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state_q <= RUN;
      wd_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
    end
  end

  assign bus.stall_o         = stall;
  assign bus.flush_o         = flush;
  assign bus.new_pc_o        = new_pc;
  assign bus.stall_timeout_o = to_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] sc_q, sc_d;
  logic [31:0] fc_q, fc_d;

  always_comb begin
    sc_d = sc_q;
    fc_d = fc_q;
    if (stall != 6'b0) sc_d = sc_q + 32'd1;
    if (flush)         fc_d = fc_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      sc_q <= 32'h0;
      fc_q <= 32'h0;
    end else begin
      sc_q <= sc_d;
      fc_q <= fc_d;
    end
  end

  assign bus.stall_cycles_o = sc_q;
  assign bus.flush_count_o  = fc_q;
`else
  assign bus.stall_cycles_o = 32'h0;
  assign bus.flush_count_o  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl, watchdog shortened to 8 cycles.
// Perf expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  logic clk;
  logic Rst_n;
  int   total;
  int   passed;

  pipe_ctrl_if bus();

  pipe_ctrl #(
    .EXC_VECTOR   (32'h0000_0020),
    .STALL_TIMEOUT(16'd8),
    .CNT_W        (16)
  ) dut (
    .clk  (clk),
    .Rst_n(Rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stallreq_if_i  = 1'b0;
    bus.stallreq_id_i  = 1'b0;
    bus.stallreq_ex_i  = 1'b0;
    bus.stallreq_mem_i = 1'b0;
    bus.except_type_i  = 32'h0;
    bus.cp0_epc_i      = 32'h0;
  endtask

  task automatic test_reset();
    Rst_n = 1'b0;
    idle();
    bus.stallreq_mem_i = 1'b1;
    bus.except_type_i  = 32'h8;
    tick();
    tick();
    total++;
    if (bus.stall_o !== 6'b0)
      $display("FAIL rst_stall got %b exp %b", bus.stall_o, 6'b0);
    else passed++;
    total++;
    if (bus.flush_o !== 1'b0)
      $display("FAIL rst_flush got %b exp 0", bus.flush_o);
    else passed++;
    total++;
    if (bus.new_pc_o !== 32'h0)
      $display("FAIL rst_pc got %h exp 0", bus.new_pc_o);
    else passed++;
    total++;
    if (bus.stall_timeout_o !== 1'b0)
      $display("FAIL rst_to got %b exp 0", bus.stall_timeout_o);
    else passed++;
    idle();
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ex_stall();
    bus.stallreq_ex_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (bus.stall_o !== 6'b001111 || bus.flush_o !== 1'b0)
        $display("FAIL ex_stall%0d got %b/%b exp 001111/0",
                 i, bus.stall_o, bus.flush_o);
      else passed++;
      tick();
    end
    bus.stallreq_ex_i = 1'b0;
    #1;
    total++;
    if (bus.stall_o !== 6'b0)
      $display("FAIL ex_release got %b exp 000000", bus.stall_o);
    else passed++;
    tick();
  endtask

  task automatic test_priority();
    bus.stallreq_id_i  = 1'b1;
    bus.stallreq_mem_i = 1'b1;
    #1;
    total++;
    if (bus.stall_o !== 6'b011111)
      $display("FAIL prio_mem got %b exp 011111", bus.stall_o);
    else passed++;
    tick();
    bus.stallreq_mem_i = 1'b0;
    #1;
    total++;
    if (bus.stall_o !== 6'b000111)
      $display("FAIL prio_id got %b exp 000111", bus.stall_o);
    else passed++;
    bus.stallreq_id_i = 1'b0;
    bus.stallreq_if_i = 1'b1;
    #1;
    total++;
    if (bus.stall_o !== 6'b000011)
      $display("FAIL prio_if got %b exp 000011", bus.stall_o);
    else passed++;
    idle();
    tick();
  endtask

  task automatic test_exception();
    bus.stallreq_mem_i = 1'b1;
    bus.except_type_i  = 32'h8;
    #1;
    total++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h20
        || bus.stall_o !== 6'b0)
      $display("FAIL exc_flush got %b/%h/%b exp 1/00000020/000000",
               bus.flush_o, bus.new_pc_o, bus.stall_o);
    else passed++;
    tick();
    #1;
    total++;
    if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0
        || bus.stall_o !== 6'b011111)
      $display("FAIL exc_hold got %b/%h/%b exp 0/00000000/011111",
               bus.flush_o, bus.new_pc_o, bus.stall_o);
    else passed++;
    tick();
    bus.stallreq_mem_i = 1'b0;
    bus.except_type_i  = 32'h5;
    #1;
    total++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'h20)
      $display("FAIL exc_unknown got %b/%h exp 1/00000020",
               bus.flush_o, bus.new_pc_o);
    else passed++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_eret();
    bus.except_type_i = 32'he;
    bus.cp0_epc_i     = 32'hbfc0_0100;
    #1;
    total++;
    if (bus.flush_o !== 1'b1 || bus.new_pc_o !== 32'hbfc0_0100)
      $display("FAIL eret got %b/%h exp 1/bfc00100",
               bus.flush_o, bus.new_pc_o);
    else passed++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset_mid_flush();
    bus.except_type_i = 32'h8;
    #1;
    total++;
    if (bus.flush_o !== 1'b1)
      $display("FAIL rmf_pre got %b exp 1", bus.flush_o);
    else passed++;
    Rst_n = 1'b0;
    #1;
    total++;
    if (bus.flush_o !== 1'b0 || bus.new_pc_o !== 32'h0)
      $display("FAIL rmf_gate got %b/%h exp 0/0",
               bus.flush_o, bus.new_pc_o);
    else passed++;
    tick();
    Rst_n = 1'b1;
    bus.except_type_i = 32'h1;
    #1;
    total++;
    if (bus.flush_o !== 1'b1)
      $display("FAIL rmf_run got %b exp 1", bus.flush_o);
    else passed++;
    tick();
    idle();
    tick();
  endtask

  task automatic test_timeout();
    bus.stallreq_if_i = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (bus.stall_timeout_o !== 1'b0)
      $display("FAIL to_early got %b exp 0", bus.stall_timeout_o);
    else passed++;
    tick();
    total++;
    if (bus.stall_timeout_o !== 1'b1)
      $display("FAIL to_set got %b exp 1", bus.stall_timeout_o);
    else passed++;
    bus.stallreq_if_i = 1'b0;
    tick();
    tick();
    total++;
    if (bus.stall_timeout_o !== 1'b1)
      $display("FAIL to_sticky got %b exp 1", bus.stall_timeout_o);
    else passed++;
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    total++;
    if (bus.stall_timeout_o !== 1'b0)
      $display("FAIL to_clear got %b exp 0", bus.stall_timeout_o);
    else passed++;
    tick();
  endtask

  task automatic test_flush_clears_wd();
    bus.stallreq_if_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.except_type_i = 32'h1;
    tick();
    bus.except_type_i = 32'h0;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (bus.stall_timeout_o !== 1'b0)
      $display("FAIL wd_flush got %b exp 0", bus.stall_timeout_o);
    else passed++;
    tick();
    total++;
    if (bus.stall_timeout_o !== 1'b1)
      $display("FAIL wd_after got %b exp 1", bus.stall_timeout_o);
    else passed++;
    idle();
    Rst_n = 1'b0;
    tick();
    Rst_n = 1'b1;
    tick();
  endtask

  task automatic test_perf();
    logic [31:0] exp_sc;
    logic [31:0] exp_fc;
`ifdef PIPE_CTRL_PERF_EN
    exp_sc = 32'd3;
    exp_fc = 32'd2;
`else
    exp_sc = 32'd0;
    exp_fc = 32'd0;
`endif
    Rst_n = 1'b0;
    idle();
    tick();
    total++;
    if (bus.stall_cycles_o !== 32'h0 || bus.flush_count_o !== 32'h0)
      $display("FAIL perf_rst got %0d/%0d exp 0/0",
               bus.stall_cycles_o, bus.flush_count_o);
    else passed++;
    Rst_n = 1'b1;
    tick();
    bus.stallreq_ex_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.stallreq_ex_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.except_type_i = 32'hc;
      tick();
      bus.except_type_i = 32'h0;
      tick();
    end
    total++;
    if (bus.stall_cycles_o !== exp_sc)
      $display("FAIL perf_stall got %0d exp %0d",
               bus.stall_cycles_o, exp_sc);
    else passed++;
    total++;
    if (bus.flush_count_o !== exp_fc)
      $display("FAIL perf_flush got %0d exp %0d",
               bus.flush_count_o, exp_fc);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    Rst_n  = 1'b0;
    idle();
    test_reset();
    test_ex_stall();
    test_priority();
    test_exception();
    test_eret();
    test_reset_mid_flush();
    test_timeout();
    test_flush_clears_wd();
    test_perf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
